// File: rtl/hms_pkg.sv
// rtl/hms_pkg.sv - shared mode/position encodings and field width for the hms alarm core
package hms_pkg;

    localparam int FIELD_W = 6;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_SETUP = 2'd1,
        MODE_ALARM = 2'd2
    } mode_t;

    localparam logic [1:0] POS_SEC  = 2'd0;
    localparam logic [1:0] POS_MIN  = 2'd1;
    localparam logic [1:0] POS_HOUR = 2'd2;

endpackage

// File: rtl/hms_field.sv
// rtl/hms_field.sv - wrap counter for one time field; en advances with carry, inc edits without carry
module hms_field
    import hms_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               inc,
    input  logic [FIELD_W-1:0] max,
    output logic [FIELD_W-1:0] value,
    output logic               carry_out
);

    // carry only propagates on a real advance, never on an edit
    assign carry_out = en && (value >= max);

    // advance or edit, wrapping to 0 after max
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (en || inc) begin
            value <= (value >= max) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/hms_alarm_core.sv
// rtl/hms_alarm_core.sv - hour:min:sec timekeeper with editable alarms, bounded ring and acknowledge
module hms_alarm_core
    import hms_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int HOUR_MAX    = 23,
    parameter int ALARM_NUM   = 2,
    parameter int ALARM_LEN_S = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_mode_next,
    input  logic                 i_pos_next,
    input  logic                 i_inc,
    input  logic                 i_alarm_sel,
    input  logic                 i_ack,
    output logic [1:0]           o_mode,
    output logic [1:0]           o_position,
    output logic [1:0]           o_alarm_idx,
    output logic [5:0]           o_sec,
    output logic [5:0]           o_min,
    output logic [5:0]           o_hour,
    output logic [ALARM_NUM-1:0] o_alarm_en,
    output logic                 o_alarm,
    output logic                 o_tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    mode_t                mode;
    logic [CNT_W-1:0]     cnt;
    logic                 tick;
    logic                 act_mode, act_pos, act_inc, act_sel;
    logic [ALARM_NUM-1:0] sel_mask, en_next, hit, ring_mask;
    logic [5:0]           ring_cnt;
    logic [5:0]           t_sec, t_min, t_hour;
    logic                 c_sec, c_min, c_hour;
    logic [5:0]           n_sec, n_min, n_hour;
    logic [5:0]           al_sec  [ALARM_NUM];
    logic [5:0]           al_min  [ALARM_NUM];
    logic [5:0]           al_hour [ALARM_NUM];

    assign o_mode = mode;
    assign tick   = (mode != MODE_SETUP) && (cnt == CNT_W'(CLK_HZ - 1));
    assign o_tick = tick;

    // one button action per cycle, highest priority first
    assign act_mode = i_mode_next;
    assign act_pos  = i_pos_next && !i_mode_next;
    assign act_inc  = i_inc && !i_mode_next && !i_pos_next;
    assign act_sel  = i_alarm_sel && !i_mode_next && !i_pos_next && !i_inc;

    // prescaler; parked at 0 in SETUP so leaving SETUP starts a full second
    always_ff @(posedge clk) begin
        if (rst || mode == MODE_SETUP || cnt == CNT_W'(CLK_HZ - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    hms_field u_sec (.clk(clk), .rst(rst), .en(tick),  .inc(act_inc && mode == MODE_SETUP && o_position == POS_SEC),
                     .max(6'd59), .value(t_sec), .carry_out(c_sec));
    hms_field u_min (.clk(clk), .rst(rst), .en(c_sec), .inc(act_inc && mode == MODE_SETUP && o_position == POS_MIN),
                     .max(6'd59), .value(t_min), .carry_out(c_min));
    hms_field u_hour(.clk(clk), .rst(rst), .en(c_min), .inc(act_inc && mode == MODE_SETUP && o_position == POS_HOUR),
                     .max(6'(HOUR_MAX)), .value(t_hour), .carry_out(c_hour));

    // time value after the current tick, used only on tick cycles for matching
    assign n_sec  = c_sec  ? 6'd0 : t_sec + 6'd1;
    assign n_min  = c_min  ? 6'd0 : (c_sec ? t_min + 6'd1 : t_min);
    assign n_hour = c_hour ? 6'd0 : (c_min ? t_hour + 6'd1 : t_hour);

    for (genvar k = 0; k < ALARM_NUM; k++) begin : g_alarm
        logic edit_k, cs, cm, ch;
        assign edit_k = act_inc && mode == MODE_ALARM && o_alarm_idx == 2'(k);
        hms_field u_asec (.clk(clk), .rst(rst), .en(1'b0), .inc(edit_k && o_position == POS_SEC),
                          .max(6'd59), .value(al_sec[k]), .carry_out(cs));
        hms_field u_amin (.clk(clk), .rst(rst), .en(cs), .inc(edit_k && o_position == POS_MIN),
                          .max(6'd59), .value(al_min[k]), .carry_out(cm));
        hms_field u_ahour(.clk(clk), .rst(rst), .en(cm), .inc(edit_k && o_position == POS_HOUR),
                          .max(6'(HOUR_MAX)), .value(al_hour[k]), .carry_out(ch));
        // alarm chains are never advanced, so ch stays low; it only qualifies the hit
        assign hit[k] = tick && o_alarm_en[k] && !ch &&
                        al_sec[k] == n_sec && al_min[k] == n_min && al_hour[k] == n_hour;
    end

    // enable toggle for the selected alarm outside ALARM mode
    always_comb begin
        sel_mask = '0;
        for (int k = 0; k < ALARM_NUM; k++) begin
            if (act_sel && mode != MODE_ALARM && o_alarm_idx == 2'(k)) sel_mask[k] = 1'b1;
        end
        en_next = o_alarm_en ^ sel_mask;
    end

    // mode / position / alarm index state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            mode        <= MODE_CLOCK;
            o_position  <= POS_SEC;
            o_alarm_idx <= 2'd0;
            o_alarm_en  <= '0;
        end else begin
            o_alarm_en <= en_next;
            if (act_mode) begin
                case (mode)
                    MODE_CLOCK: mode <= MODE_SETUP;
                    MODE_SETUP: mode <= MODE_ALARM;
                    default:    mode <= MODE_CLOCK;
                endcase
                o_position <= POS_SEC;
            end else if (act_pos) begin
                o_position <= (o_position == POS_HOUR) ? POS_SEC : o_position + 2'd1;
            end else if (act_sel && mode == MODE_ALARM) begin
                o_alarm_idx <= (o_alarm_idx == 2'(ALARM_NUM - 1)) ? 2'd0 : o_alarm_idx + 2'd1;
            end
        end
    end

    // ring control: a fresh match always wins over ack and restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            o_alarm   <= 1'b0;
            ring_cnt  <= '0;
            ring_mask <= '0;
        end else if (|hit) begin
            o_alarm   <= 1'b1;
            ring_cnt  <= 6'(ALARM_LEN_S);
            ring_mask <= hit;
        end else if (o_alarm) begin
            if (i_ack || (ring_mask & en_next) == '0 || ring_cnt == 6'd0) begin
                o_alarm <= 1'b0;
            end else if (tick) begin
                ring_cnt <= ring_cnt - 6'd1;
            end
        end
    end

    // display mux: ALARM mode shows the selected alarm
    always_comb begin
        o_sec  = t_sec;
        o_min  = t_min;
        o_hour = t_hour;
        if (mode == MODE_ALARM) begin
            for (int k = 0; k < ALARM_NUM; k++) begin
                if (o_alarm_idx == 2'(k)) begin
                    o_sec  = al_sec[k];
                    o_min  = al_min[k];
                    o_hour = al_hour[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_hms_alarm_core.sv
// tb/tb_hms_alarm_core.sv - self-checking bench for hms_alarm_core against a seconds-count model
module tb_hms_alarm_core;

    localparam int CLK_HZ = 10, HOUR_MAX = 23, N = 2, LEN = 3;
    localparam int DAY = (HOUR_MAX + 1) * 3600;

    logic clk = 1'b0, rst = 1'b1;
    logic mode_next = 0, pos_next = 0, inc = 0, alarm_sel = 0, ack = 0;
    logic [1:0] mode, position, alarm_idx;
    logic [5:0] sec, min, hour;
    logic [N-1:0] alarm_en;
    logic alarm, tick;

    hms_alarm_core #(.CLK_HZ(CLK_HZ), .HOUR_MAX(HOUR_MAX), .ALARM_NUM(N), .ALARM_LEN_S(LEN)) dut (
        .clk(clk), .rst(rst), .i_mode_next(mode_next), .i_pos_next(pos_next), .i_inc(inc),
        .i_alarm_sel(alarm_sel), .i_ack(ack), .o_mode(mode), .o_position(position),
        .o_alarm_idx(alarm_idx), .o_sec(sec), .o_min(min), .o_hour(hour),
        .o_alarm_en(alarm_en), .o_alarm(alarm), .o_tick(tick));

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    // model: time and alarms as seconds-of-day, prescaler as cycles since last second
    int m_mode, m_pos, m_idx, m_t, m_ps, m_tk;
    int m_as [N];
    bit m_en [N];
    bit m_mask [N];
    bit m_ring;

    function automatic int bump(input int t, input int p);
        int h, m, s;
        h = t / 3600; m = (t / 60) % 60; s = t % 60;
        if (p == 0) s = (s + 1) % 60;
        else if (p == 1) m = (m + 1) % 60;
        else h = (h + 1) % (HOUR_MAX + 1);
        return h * 3600 + m * 60 + s;
    endfunction

    task automatic model_step(input bit r, input bit mn, input bit pn, input bit ic, input bit sl, input bit ak);
        bit tk, any, keep;
        bit hit [N];
        if (r) begin
            m_mode = 0; m_pos = 0; m_idx = 0; m_t = 0; m_ps = 0; m_tk = 0; m_ring = 0;
            for (int k = 0; k < N; k++) begin m_as[k] = 0; m_en[k] = 0; m_mask[k] = 0; end
            return;
        end
        tk = (m_mode != 1) && (m_ps == CLK_HZ - 1);
        if (tk) m_t = (m_t + 1) % DAY;
        any = 0;
        for (int k = 0; k < N; k++) begin
            hit[k] = tk && m_en[k] && (m_as[k] == m_t);
            any |= hit[k];
        end
        m_ps = (m_mode == 1 || m_ps == CLK_HZ - 1) ? 0 : m_ps + 1;
        if (mn) begin m_mode = (m_mode + 1) % 3; m_pos = 0; end
        else if (pn) m_pos = (m_pos + 1) % 3;
        else if (ic) begin
            if (m_mode == 1) m_t = bump(m_t, m_pos);
            else if (m_mode == 2) m_as[m_idx] = bump(m_as[m_idx], m_pos);
        end else if (sl) begin
            if (m_mode == 2) m_idx = (m_idx + 1) % N;
            else m_en[m_idx] = !m_en[m_idx];
        end
        keep = 0;
        for (int k = 0; k < N; k++) keep |= m_mask[k] && m_en[k];
        if (any) begin
            m_ring = 1; m_tk = 0;
            for (int k = 0; k < N; k++) m_mask[k] = hit[k];
        end else if (m_ring) begin
            if (ak || !keep || m_tk == LEN) m_ring = 0;
            else if (tk) m_tk++;
        end
    endtask

    task automatic check_cycle();
        int disp;
        logic [N-1:0] een;
        logic et;
        disp = (m_mode == 2) ? m_as[m_idx] : m_t;
        for (int k = 0; k < N; k++) een[k] = m_en[k];
        et = (m_mode != 1) && (m_ps == CLK_HZ - 1);
        n_checks++;
        if (mode !== 2'(m_mode) || position !== 2'(m_pos) || alarm_idx !== 2'(m_idx) ||
            sec !== 6'(disp % 60) || min !== 6'((disp / 60) % 60) || hour !== 6'(disp / 3600) ||
            alarm_en !== een || alarm !== m_ring || tick !== et) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t got mode=%0d pos=%0d idx=%0d %0d:%0d:%0d en=%b alarm=%b tick=%b exp mode=%0d pos=%0d idx=%0d %0d:%0d:%0d en=%b alarm=%b tick=%b",
                     $time, mode, position, alarm_idx, hour, min, sec, alarm_en, alarm, tick,
                     m_mode, m_pos, m_idx, disp / 3600, (disp / 60) % 60, disp % 60, een, m_ring, et);
        end
    endtask

    task automatic cycle(input bit r, input bit mn, input bit pn, input bit ic, input bit sl, input bit ak);
        @(negedge clk);
        rst = r; mode_next = mn; pos_next = pn; inc = ic; alarm_sel = sl; ack = ak;
        @(posedge clk);
        model_step(r, mn, pn, ic, sl, ak);
        #1 check_cycle();
    endtask

    task automatic idle();           cycle(0, 0, 0, 0, 0, 0); endtask
    task automatic do_reset();       cycle(1, 0, 0, 0, 0, 0); endtask
    task automatic press_mode();     cycle(0, 1, 0, 0, 0, 0); endtask
    task automatic press_pos();      cycle(0, 0, 1, 0, 0, 0); endtask
    task automatic press_inc();      cycle(0, 0, 0, 1, 0, 0); endtask
    task automatic press_sel();      cycle(0, 0, 0, 0, 1, 0); endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic set_alarm(input int k, input int s, input bit enable);
        press_mode(); press_mode();
        repeat (k) press_sel();
        repeat (s) press_inc();
        press_mode();
        if (enable) press_sel();
    endtask

    task automatic wait_alarm(input int budget);
        int n = 0;
        while (alarm !== 1'b1 && n < budget) begin idle(); n++; end
        chk("alarm_rise", int'(alarm), 1);
    endtask

    task automatic wait_tick(input int budget);
        int n = 0;
        while (tick !== 1'b1 && n < budget) begin idle(); n++; end
        chk("tick_seen", int'(tick), 1);
    endtask

    initial begin
        int cnt, hi, n;
        bit seen;

        do_reset();
        chk("rst_mode", mode, 0); chk("rst_sec", sec, 0); chk("rst_en", alarm_en, 0); chk("rst_alarm", alarm, 0);

        cnt = 0;
        repeat (600) begin idle(); if (tick) cnt++; end
        chk("tick_count_600", cnt, 60); chk("run_min", min, 1); chk("run_sec", sec, 0); chk("run_hour", hour, 0);

        do_reset(); press_mode();
        repeat (59) press_inc(); press_pos();
        repeat (59) press_inc(); press_pos();
        repeat (23) press_inc();
        chk("set_hour", hour, 23); chk("set_min", min, 59); chk("set_sec", sec, 59);
        press_mode(); press_mode();
        chk("back_clock", mode, 0);
        wait_tick(50); idle();
        chk("wrap_hour", hour, 0); chk("wrap_min", min, 0); chk("wrap_sec", sec, 0);

        do_reset(); press_mode();
        repeat (3) press_inc();
        cnt = 0;
        repeat (100) begin idle(); if (tick) cnt++; end
        chk("setup_sec", sec, 3); chk("setup_no_tick", cnt, 0);

        do_reset(); set_alarm(0, 5, 1);
        n = 0;
        while (sec !== 6'd5 && n < 200) begin idle(); n++; end
        chk("sec5_reached", sec, 5); chk("alarm_at_sec5", alarm, 1);
        hi = 1; n = 0;
        while (alarm === 1'b1 && n < 200) begin idle(); n++; if (alarm) hi++; end
        chk("ring_cycles", hi, 31);

        do_reset(); set_alarm(0, 5, 1);
        wait_alarm(200); wait_tick(20);
        cycle(0, 0, 0, 0, 0, 1);
        chk("ack_clears", alarm, 0);

        do_reset(); idle();
        cycle(0, 1, 0, 1, 0, 0);
        chk("prio_mode", mode, 1); chk("prio_sec", sec, 0);

        do_reset(); set_alarm(1, 5, 0);
        seen = 0;
        repeat (150) begin idle(); if (alarm) seen = 1; end
        chk("disabled_no_ring", int'(seen), 0); chk("disabled_en", alarm_en, 0);

        do_reset(); set_alarm(0, 5, 1);
        wait_alarm(200);
        do_reset();
        chk("rst_ring_alarm", alarm, 0); chk("rst_ring_mode", mode, 0); chk("rst_ring_sec", sec, 0);

        do_reset();
        repeat (20000) begin
            cycle($urandom_range(0, 3999) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
